// File: rtl/execute_stage.sv
// ----------------------------------------------------------------------------
// execute_stage
//
// Execute (E) stage of the 5-stage MIPS pipeline.
//   - Chooses the RS and RT operands from the D/E register or from forwarded
//     values in later stages (FRS, FRT).
//   - Computes the ALU result for the instruction in IRE.
//   - Loads the E/M pipeline register every rising clock edge.
//
// Ports:
//   Clk              in   1   system clock, rising-edge active
//   Reset            in   1   synchronous, active-high reset
//   IRE              in  32   instruction in E
//   PC8E             in  32   PC+8 of instruction in E
//   RSE, RTE         in  32   register values read in D
//   EXTE             in  32   extended 16-bit immediate
//   Forward_RS_E_Sel in   3   RS operand select (hazard unit)
//   Forward_RT_E_Sel in   3   RT operand select (hazard unit)
//   AO               in  32   ALU result held in M
//   PC8fromM         in  32   PC+8 held in M (link value)
//   MUX_RF_WD_OUT    in  32   W-stage register-file write data
//   IRM, PC8M        out 32   registered IRE, PC8E
//   AOM              out 32   registered ALU result
//   RTM              out 32   registered forwarded RT (store data)
// ----------------------------------------------------------------------------
module execute_stage (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] IRE,
    input  logic [31:0] PC8E,
    input  logic [31:0] RSE,
    input  logic [31:0] RTE,
    input  logic [31:0] EXTE,
    input  logic [2:0]  Forward_RS_E_Sel,
    input  logic [2:0]  Forward_RT_E_Sel,
    input  logic [31:0] AO,
    input  logic [31:0] PC8fromM,
    input  logic [31:0] MUX_RF_WD_OUT,
    output logic [31:0] IRM,
    output logic [31:0] PC8M,
    output logic [31:0] AOM,
    output logic [31:0] RTM
);

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    logic [31:0] frs;
    logic [31:0] frt;
    logic [31:0] alu_result;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;

    assign opcode = IRE[31:26];
    assign funct  = IRE[5:0];
    assign shamt  = IRE[10:6];

    // Forwarding muxes. Codes 4-7 are unused by the hazard unit and fall
    // back to the D-stage register value.
    always_comb begin
        case (Forward_RS_E_Sel)
            3'd1:    frs = AO;
            3'd2:    frs = PC8fromM;
            3'd3:    frs = MUX_RF_WD_OUT;
            default: frs = RSE;
        endcase
    end

    always_comb begin
        case (Forward_RT_E_Sel)
            3'd1:    frt = AO;
            3'd2:    frt = PC8fromM;
            3'd3:    frt = MUX_RF_WD_OUT;
            default: frt = RTE;
        endcase
    end

    // ALU. No overflow trapping: add/addi/sub wrap exactly like their
    // unsigned counterparts. Anything not listed (jr, jalr, branches,
    // jumps) produces 0.
    always_comb begin
        alu_result = 32'h0000_0000;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD,  FN_ADDU: alu_result = frs + frt;
                    FN_SUB,  FN_SUBU: alu_result = frs - frt;
                    FN_AND:  alu_result = frs & frt;
                    FN_OR:   alu_result = frs | frt;
                    FN_XOR:  alu_result = frs ^ frt;
                    FN_NOR:  alu_result = ~(frs | frt);
                    FN_SLT:  alu_result = {31'd0, $signed(frs) < $signed(frt)};
                    FN_SLTU: alu_result = {31'd0, frs < frt};
                    FN_SLL:  alu_result = frt << shamt;
                    FN_SRL:  alu_result = frt >> shamt;
                    FN_SRA:  alu_result = $unsigned($signed(frt) >>> shamt);
                    FN_SLLV: alu_result = frt << frs[4:0];
                    FN_SRLV: alu_result = frt >> frs[4:0];
                    FN_SRAV: alu_result = $unsigned($signed(frt) >>> frs[4:0]);
                    default: alu_result = 32'h0000_0000;
                endcase
            end
            OP_ADDI, OP_ADDIU: alu_result = frs + EXTE;
            OP_SLTI:  alu_result = {31'd0, $signed(frs) < $signed(EXTE)};
            OP_SLTIU: alu_result = {31'd0, frs < EXTE};
            OP_ANDI:  alu_result = frs & EXTE;
            OP_ORI:   alu_result = frs | EXTE;
            OP_XORI:  alu_result = frs ^ EXTE;
            // lui takes the raw immediate field, not the extended one
            OP_LUI:   alu_result = {IRE[15:0], 16'h0000};
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: alu_result = frs + EXTE;
            default:  alu_result = 32'h0000_0000;
        endcase
    end

    // E/M pipeline register: no stall, loads every edge; reset dominates.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            IRM  <= 32'h0000_0000;
            PC8M <= 32'h0000_0000;
            AOM  <= 32'h0000_0000;
            RTM  <= 32'h0000_0000;
        end else begin
            IRM  <= IRE;
            PC8M <= PC8E;
            AOM  <= alu_result;
            RTM  <= frt;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// ----------------------------------------------------------------------------
// tb_execute_stage
//
// Directed bench for execute_stage. Each step drives one instruction on the
// falling edge, pushes the hand-computed AOM into exp_q, and after the next
// rising edge pops it and compares the E/M register outputs.
// ----------------------------------------------------------------------------
module tb_execute_stage;

    logic        clk;
    logic        reset;
    logic [31:0] ire, pc8e, rse, rte, exte;
    logic [2:0]  fwd_rs_sel, fwd_rt_sel;
    logic [31:0] ao, pc8_from_m, rf_wd;
    logic [31:0] irm, pc8m, aom, rtm;

    int tests_run;
    int tests_failed;
    logic [31:0] exp_q[$];

    execute_stage dut (
        .Clk              (clk),
        .Reset            (reset),
        .IRE              (ire),
        .PC8E             (pc8e),
        .RSE              (rse),
        .RTE              (rte),
        .EXTE             (exte),
        .Forward_RS_E_Sel (fwd_rs_sel),
        .Forward_RT_E_Sel (fwd_rt_sel),
        .AO               (ao),
        .PC8fromM         (pc8_from_m),
        .MUX_RF_WD_OUT    (rf_wd),
        .IRM              (irm),
        .PC8M             (pc8m),
        .AOM              (aom),
        .RTM              (rtm)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [31:0] i_ire, input logic [31:0] i_pc8e,
                         input logic [31:0] i_rse, input logic [31:0] i_rte,
                         input logic [31:0] i_exte,
                         input logic [2:0] i_frs, input logic [2:0] i_frt);
        @(negedge clk);
        ire        = i_ire;
        pc8e       = i_pc8e;
        rse        = i_rse;
        rte        = i_rte;
        exte       = i_exte;
        fwd_rs_sel = i_frs;
        fwd_rt_sel = i_frt;
    endtask

    task automatic set_fwd(input logic [31:0] i_ao, input logic [31:0] i_pc8m,
                           input logic [31:0] i_wd);
        ao         = i_ao;
        pc8_from_m = i_pc8m;
        rf_wd      = i_wd;
    endtask

    task automatic clock_edge();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_aom(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, aom, e);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        ire = 32'h0; pc8e = 32'h0; rse = 32'h0; rte = 32'h0; exte = 32'h0;
        fwd_rs_sel = 3'd0; fwd_rt_sel = 3'd0;
        set_fwd(32'h0, 32'h0, 32'h0);

        // Reset with random inputs
        drive($urandom, $urandom, $urandom, $urandom, $urandom,
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        set_fwd($urandom, $urandom, $urandom);
        clock_edge();
        check("rst_irm", irm, 32'h0);
        check("rst_pc8m", pc8m, 32'h0);
        check("rst_aom", aom, 32'h0);
        check("rst_rtm", rtm, 32'h0);

        // addu $3,$1,$2 with no forwarding
        reset = 1'b0;
        set_fwd(32'h100, 32'h3010, 32'h20);
        drive(32'h00221821, 32'h3008, 32'd5, 32'd7, 32'h0, 3'd0, 3'd0);
        exp_q.push_back(32'd12);
        clock_edge();
        check_aom("addu_aom");
        check("addu_irm", irm, 32'h00221821);
        check("addu_pc8m", pc8m, 32'h3008);
        check("addu_rtm", rtm, 32'd7);

        // RS forwarding selects
        drive(32'h00221821, 32'h3008, 32'd5, 32'd7, 32'h0, 3'd1, 3'd0);
        exp_q.push_back(32'h107);
        clock_edge();
        check_aom("fwd_rs_ao");
        drive(32'h00221821, 32'h3008, 32'd5, 32'd7, 32'h0, 3'd2, 3'd0);
        exp_q.push_back(32'h3017);
        clock_edge();
        check_aom("fwd_rs_pc8");
        drive(32'h00221821, 32'h300C, 32'd5, 32'd7, 32'h0, 3'd3, 3'd0);
        exp_q.push_back(32'h27);
        clock_edge();
        check_aom("fwd_rs_wd");
        check("fwd_pc8m_pass", pc8m, 32'h300C);
        drive(32'h00221821, 32'h3008, 32'd5, 32'd7, 32'h0, 3'd5, 3'd6);
        exp_q.push_back(32'd12);
        clock_edge();
        check_aom("fwd_sel_hi_aom");
        check("fwd_sel_hi_rtm", rtm, 32'd7);

        // ori / lui (lui ignores EXTE)
        drive(32'h34220F0F, 32'h4, 32'hF0F00000, 32'h0, 32'h00000F0F, 3'd0, 3'd0);
        exp_q.push_back(32'hF0F00F0F);
        clock_edge();
        check_aom("ori");
        drive(32'h3C011234, 32'h8, 32'h0000FFFF, 32'h0, 32'hFFFFFFFF, 3'd0, 3'd0);
        exp_q.push_back(32'h12340000);
        clock_edge();
        check_aom("lui");

        // sw: address and store data, then forwarded store data
        drive(32'hAC220004, 32'hC, 32'h1000, 32'hDEADBEEF, 32'h4, 3'd0, 3'd0);
        exp_q.push_back(32'h1004);
        clock_edge();
        check_aom("sw_addr");
        check("sw_rtm", rtm, 32'hDEADBEEF);
        set_fwd(32'h100, 32'h3010, 32'h55);
        drive(32'hAC220004, 32'hC, 32'h1000, 32'hDEADBEEF, 32'h4, 3'd0, 3'd3);
        exp_q.push_back(32'h1004);
        clock_edge();
        check_aom("sw_fwd_addr");
        check("sw_fwd_rtm", rtm, 32'h55);

        // lw with negative offset
        drive(32'h8C22FFFC, 32'h10, 32'h2000, 32'h0, 32'hFFFFFFFC, 3'd0, 3'd0);
        exp_q.push_back(32'h00001FFC);
        clock_edge();
        check_aom("lw_neg_off");

        // Shifts
        drive(32'h00021903, 32'h14, 32'h0, 32'h80000000, 32'h0, 3'd0, 3'd0);
        exp_q.push_back(32'hF8000000);
        clock_edge();
        check_aom("sra");
        drive(32'h00021902, 32'h14, 32'h0, 32'h80000000, 32'h0, 3'd0, 3'd0);
        exp_q.push_back(32'h08000000);
        clock_edge();
        check_aom("srl");
        drive(32'h00221807, 32'h18, 32'h24, 32'h80000010, 32'h0, 3'd0, 3'd0);
        exp_q.push_back(32'hF8000001);
        clock_edge();
        check_aom("srav");
        drive(32'h00221804, 32'h18, 32'h8, 32'h000000FF, 32'h0, 3'd0, 3'd0);
        exp_q.push_back(32'h0000FF00);
        clock_edge();
        check_aom("sllv");

        // Arithmetic/logic R-type
        drive(32'h00221822, 32'h1C, 32'd3, 32'd5, 32'h0, 3'd0, 3'd0);
        exp_q.push_back(32'hFFFFFFFE);
        clock_edge();
        check_aom("sub_wrap");
        drive(32'h00221827, 32'h1C, 32'h0F0F0000, 32'h000000FF, 32'h0, 3'd0, 3'd0);
        exp_q.push_back(32'hF0F0FF00);
        clock_edge();
        check_aom("nor");
        drive(32'h0022182A, 32'h20, 32'hFFFFFFFF, 32'd1, 32'h0, 3'd0, 3'd0);
        exp_q.push_back(32'd1);
        clock_edge();
        check_aom("slt_signed");
        drive(32'h0022182B, 32'h20, 32'hFFFFFFFF, 32'd1, 32'h0, 3'd0, 3'd0);
        exp_q.push_back(32'd0);
        clock_edge();
        check_aom("sltu_unsigned");

        // Immediate compares: 5 < -1 signed is false, unsigned is true
        drive(32'h2822FFFF, 32'h24, 32'd5, 32'h0, 32'hFFFFFFFF, 3'd0, 3'd0);
        exp_q.push_back(32'd0);
        clock_edge();
        check_aom("slti");
        drive(32'h2C22FFFF, 32'h24, 32'd5, 32'h0, 32'hFFFFFFFF, 3'd0, 3'd0);
        exp_q.push_back(32'd1);
        clock_edge();
        check_aom("sltiu");

        // Zero-result cases: j, jr, bubble
        drive(32'h08000000, 32'h28, 32'h1234, 32'h5678, 32'h9, 3'd0, 3'd0);
        exp_q.push_back(32'h0);
        clock_edge();
        check_aom("j_zero");
        drive(32'h00200008, 32'h2C, 32'd123, 32'h0, 32'h0, 3'd0, 3'd0);
        exp_q.push_back(32'h0);
        clock_edge();
        check_aom("jr_zero");
        drive(32'h00000000, 32'h30, 32'hABCD, 32'h0, 32'h0, 3'd0, 3'd0);
        exp_q.push_back(32'h0);
        clock_edge();
        check_aom("bubble");
        check("bubble_irm", irm, 32'h0);

        // Mid-stream reset beats the data path, then resumes
        drive(32'h00221821, 32'h3008, 32'd5, 32'd7, 32'h0, 3'd0, 3'd0);
        reset = 1'b1;
        clock_edge();
        check("mid_rst_irm", irm, 32'h0);
        check("mid_rst_pc8m", pc8m, 32'h0);
        check("mid_rst_aom", aom, 32'h0);
        check("mid_rst_rtm", rtm, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(32'd12);
        clock_edge();
        check_aom("post_rst_aom");
        check("post_rst_irm", irm, 32'h00221821);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
